// File: rtl/ddr_loss_list_arbiter_pkg.sv
// Shared definitions for the DDR3 loss-list arbiter: FSM encodings,
// fixed AXI attributes and master indices.
package ddr_loss_list_arbiter_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE      = 4'b0011;
    localparam logic [2:0] AXI_PROT       = 3'b000;
    localparam logic [3:0] AXI_QOS        = 4'b0000;
    localparam logic       AXI_LOCK       = 1'b0;

    localparam logic MST_SEND = 1'b0;
    localparam logic MST_RECV = 1'b1;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/ddr_loss_list_arbiter_if.sv
// Bus bundle for the arbiter: two concatenated master ports on the m_* side,
// the single MIG AXI port on the s_axi_* side.
interface ddr_loss_list_arbiter_if #(
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_S_AXI_ADDR_WIDTH = 32
);
    localparam int IW = C_S_AXI_ID_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    logic [2*AW-1:0] m_awaddr;
    logic [15:0]     m_awlen;
    logic [1:0]      m_awvalid, m_awready;
    logic [2*DW-1:0] m_wdata;
    logic [2*SW-1:0] m_wstrb;
    logic [1:0]      m_wlast, m_wvalid, m_wready;
    logic [1:0]      m_bresp, m_bvalid, m_bready;
    logic [2*AW-1:0] m_araddr;
    logic [15:0]     m_arlen;
    logic [1:0]      m_arvalid, m_arready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [1:0]      m_rvalid, m_rready;

    logic [IW-1:0]   s_axi_awid;
    logic [AW-1:0]   s_axi_awaddr;
    logic [7:0]      s_axi_awlen;
    logic [2:0]      s_axi_awsize;
    logic [1:0]      s_axi_awburst;
    logic            s_axi_awlock;
    logic [3:0]      s_axi_awcache;
    logic [2:0]      s_axi_awprot;
    logic [3:0]      s_axi_awqos;
    logic            s_axi_awvalid, s_axi_awready;
    logic [DW-1:0]   s_axi_wdata;
    logic [SW-1:0]   s_axi_wstrb;
    logic            s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic            s_axi_bready;
    logic [IW-1:0]   s_axi_bid;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic [IW-1:0]   s_axi_arid;
    logic [AW-1:0]   s_axi_araddr;
    logic [7:0]      s_axi_arlen;
    logic [2:0]      s_axi_arsize;
    logic [1:0]      s_axi_arburst;
    logic            s_axi_arlock;
    logic [3:0]      s_axi_arcache;
    logic [2:0]      s_axi_arprot;
    logic [3:0]      s_axi_arqos;
    logic            s_axi_arvalid, s_axi_arready;
    logic            s_axi_rready;
    logic [IW-1:0]   s_axi_rid;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast, s_axi_rvalid;

    // Arbiter view: it is the slave of both loss-list masters.
    modport slave (
        input  m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid,
               m_bready, m_araddr, m_arlen, m_arvalid, m_rready,
               s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output m_awready, m_wready, m_bresp, m_bvalid, m_arready,
               m_rdata, m_rresp, m_rlast, m_rvalid,
               s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
               s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
               s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
               s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
               s_axi_rready
    );

    modport master (
        output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid,
               m_bready, m_araddr, m_arlen, m_arvalid, m_rready,
               s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  m_awready, m_wready, m_bresp, m_bvalid, m_arready,
               m_rdata, m_rresp, m_rlast, m_rvalid,
               s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
               s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
               s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
               s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
               s_axi_rready
    );

endinterface

// File: rtl/ddr_loss_list_arbiter_axi_rr_grant.sv
// Two-input round-robin picker. The last-grant bit resets to master 1 so
// master 0 wins the first contested round.
module axi_rr_grant
    import ddr_loss_list_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_grant
);

    logic r_last;

    always_comb begin
        if (&i_req) o_grant = ~r_last;
        else        o_grant = i_req[1] ? MST_RECV : MST_SEND;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_last <= MST_RECV;
        else if (i_take) r_last <= o_grant;
    end

endmodule

// File: rtl/ddr_loss_list_arbiter.sv
// Shares the MIG AXI port between the send and receive loss-list managers.
// Write and read paths are granted independently, one whole burst per grant.
//
// state   | meaning
// W_IDLE  | waiting for calibration and an AW request; accepts the winner's AW
// W_ADDR  | presenting the rebased AW to DDR until accepted
// W_DATA  | W beats pass through from the granted master until wlast
// W_RESP  | B response routed back to the granted master
// R_IDLE  | waiting for calibration and an AR request; accepts the winner's AR
// R_ADDR  | presenting the rebased AR to DDR until accepted
// R_DATA  | R beats routed to the granted master until rlast
module ddr_loss_list_arbiter
    import ddr_loss_list_arbiter_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] M0_BASE = 32'h0000_0000,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] M1_BASE = 32'h0000_1000
) (
    input logic                    core_clk,
    input logic                    core_rst,
    input logic                    init_calib_complete,
    ddr_loss_list_arbiter_if.slave bus
);

    localparam int IW = C_S_AXI_ID_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    w_state_t        r_wstate, w_wstate_nxt;
    r_state_t        r_rstate, w_rstate_nxt;
    logic            r_wgnt, r_rgnt;
    logic [AW-1:0]   r_awaddr, r_araddr;
    logic [7:0]      r_awlen, r_arlen;
    logic [IW-1:0]   r_awid, r_arid;

    logic            w_go, w_aw_gnt, w_ar_gnt, w_aw_take, w_ar_take;
    logic [1:0]      w_m_awready, w_m_wready, w_m_bvalid, w_m_arready, w_m_rvalid;
    logic            w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
    logic            w_sel_wvalid, w_sel_wlast, w_sel_bready, w_sel_rready;
    logic [DW-1:0]   w_sel_wdata;
    logic [SW-1:0]   w_sel_wstrb;
    logic            w_unused_ids;

    // Grants are also held off while reset is asserted so no ready leaks out.
    assign w_go      = init_calib_complete & ~core_rst;
    assign w_aw_take = (r_wstate == W_IDLE) & w_go & (|bus.m_awvalid);
    assign w_ar_take = (r_rstate == R_IDLE) & w_go & (|bus.m_arvalid);

    axi_rr_grant u_aw_grant (
        .i_clk   (core_clk),
        .i_rst   (core_rst),
        .i_req   (bus.m_awvalid),
        .i_take  (w_aw_take),
        .o_grant (w_aw_gnt)
    );

    axi_rr_grant u_ar_grant (
        .i_clk   (core_clk),
        .i_rst   (core_rst),
        .i_req   (bus.m_arvalid),
        .i_take  (w_ar_take),
        .o_grant (w_ar_gnt)
    );

    assign w_sel_wdata  = r_wgnt ? bus.m_wdata[2*DW-1:DW] : bus.m_wdata[DW-1:0];
    assign w_sel_wstrb  = r_wgnt ? bus.m_wstrb[2*SW-1:SW] : bus.m_wstrb[SW-1:0];
    assign w_sel_wlast  = bus.m_wlast[r_wgnt];
    assign w_sel_wvalid = bus.m_wvalid[r_wgnt];
    assign w_sel_bready = bus.m_bready[r_wgnt];
    assign w_sel_rready = bus.m_rready[r_rgnt];

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            r_wstate <= W_IDLE;
            r_wgnt   <= MST_SEND;
            r_awaddr <= '0;
            r_awlen  <= '0;
            r_awid   <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_take) begin
                r_wgnt   <= w_aw_gnt;
                r_awaddr <= w_aw_gnt ? M1_BASE + bus.m_awaddr[2*AW-1:AW]
                                     : M0_BASE + bus.m_awaddr[AW-1:0];
                r_awlen  <= w_aw_gnt ? bus.m_awlen[15:8] : bus.m_awlen[7:0];
                r_awid   <= IW'(w_aw_gnt);
            end
        end
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            r_rstate <= R_IDLE;
            r_rgnt   <= MST_SEND;
            r_araddr <= '0;
            r_arlen  <= '0;
            r_arid   <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_take) begin
                r_rgnt   <= w_ar_gnt;
                r_araddr <= w_ar_gnt ? M1_BASE + bus.m_araddr[2*AW-1:AW]
                                     : M0_BASE + bus.m_araddr[AW-1:0];
                r_arlen  <= w_ar_gnt ? bus.m_arlen[15:8] : bus.m_arlen[7:0];
                r_arid   <= IW'(w_ar_gnt);
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_m_awready  = '0;
        w_m_wready   = '0;
        w_m_bvalid   = '0;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_take) begin
                    w_m_awready[w_aw_gnt] = 1'b1;
                    w_wstate_nxt          = W_ADDR;
                end
            end
            W_ADDR: begin
                w_awvalid = 1'b1;
                if (bus.s_axi_awready) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                w_wvalid             = w_sel_wvalid;
                w_m_wready[r_wgnt]   = bus.s_axi_wready;
                if (w_sel_wvalid && bus.s_axi_wready && w_sel_wlast) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                w_bready             = w_sel_bready;
                w_m_bvalid[r_wgnt]   = bus.s_axi_bvalid;
                if (bus.s_axi_bvalid && w_sel_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_m_arready  = '0;
        w_m_rvalid   = '0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_take) begin
                    w_m_arready[w_ar_gnt] = 1'b1;
                    w_rstate_nxt          = R_ADDR;
                end
            end
            R_ADDR: begin
                w_arvalid = 1'b1;
                if (bus.s_axi_arready) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                w_rready             = w_sel_rready;
                w_m_rvalid[r_rgnt]   = bus.s_axi_rvalid;
                if (bus.s_axi_rvalid && w_sel_rready && bus.s_axi_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign bus.m_awready     = w_m_awready;
    assign bus.m_wready      = w_m_wready;
    assign bus.m_bvalid      = w_m_bvalid;
    assign bus.m_bresp       = bus.s_axi_bresp;
    assign bus.m_arready     = w_m_arready;
    assign bus.m_rvalid      = w_m_rvalid;
    assign bus.m_rdata       = bus.s_axi_rdata;
    assign bus.m_rresp       = bus.s_axi_rresp;
    assign bus.m_rlast       = bus.s_axi_rlast;

    assign bus.s_axi_awid    = r_awid;
    assign bus.s_axi_awaddr  = r_awaddr;
    assign bus.s_axi_awlen   = r_awlen;
    assign bus.s_axi_awsize  = axi_size(DW);
    assign bus.s_axi_awburst = AXI_BURST_INCR;
    assign bus.s_axi_awlock  = AXI_LOCK;
    assign bus.s_axi_awcache = AXI_CACHE;
    assign bus.s_axi_awprot  = AXI_PROT;
    assign bus.s_axi_awqos   = AXI_QOS;
    assign bus.s_axi_awvalid = w_awvalid;
    assign bus.s_axi_wdata   = w_sel_wdata;
    assign bus.s_axi_wstrb   = w_sel_wstrb;
    assign bus.s_axi_wlast   = w_sel_wlast;
    assign bus.s_axi_wvalid  = w_wvalid;
    assign bus.s_axi_bready  = w_bready;

    assign bus.s_axi_arid    = r_arid;
    assign bus.s_axi_araddr  = r_araddr;
    assign bus.s_axi_arlen   = r_arlen;
    assign bus.s_axi_arsize  = axi_size(DW);
    assign bus.s_axi_arburst = AXI_BURST_INCR;
    assign bus.s_axi_arlock  = AXI_LOCK;
    assign bus.s_axi_arcache = AXI_CACHE;
    assign bus.s_axi_arprot  = AXI_PROT;
    assign bus.s_axi_arqos   = AXI_QOS;
    assign bus.s_axi_arvalid = w_arvalid;
    assign bus.s_axi_rready  = w_rready;

    // Response routing follows the registered grant; DDR-side IDs are not needed.
    assign w_unused_ids = ^{bus.s_axi_bid, bus.s_axi_rid};

endmodule

// File: tb/tb_ddr_loss_list_arbiter.sv
// Directed bench for ddr_loss_list_arbiter: calibration gating, rebasing,
// round-robin order, concurrent read/write, stalls and mid-burst reset.
module tb_ddr_loss_list_arbiter;

    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    logic init_calib_complete = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    ddr_loss_list_arbiter_if #(
        .C_S_AXI_ID_WIDTH(4), .C_S_AXI_DATA_WIDTH(512), .C_S_AXI_ADDR_WIDTH(32)
    ) bus ();

    ddr_loss_list_arbiter #(
        .C_S_AXI_ID_WIDTH(4), .C_S_AXI_DATA_WIDTH(512), .C_S_AXI_ADDR_WIDTH(32),
        .M0_BASE(32'h0000_0000), .M1_BASE(32'h0000_1000)
    ) dut (
        .core_clk            (core_clk),
        .core_rst            (core_rst),
        .init_calib_complete (init_calib_complete),
        .bus                 (bus)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [511:0] pat(input int k);
        return {16{32'hC0DE_0000 + 32'(k)}};
    endfunction

    task automatic tick();
        @(posedge core_clk);
        @(negedge core_clk);
    endtask

    task automatic idle_all();
        bus.m_awaddr = '0; bus.m_awlen = '0; bus.m_awvalid = '0;
        bus.m_wdata = '0; bus.m_wstrb = '1; bus.m_wlast = '0; bus.m_wvalid = '0;
        bus.m_bready = '0;
        bus.m_araddr = '0; bus.m_arlen = '0; bus.m_arvalid = '0; bus.m_rready = '0;
        bus.s_axi_awready = 1'b0; bus.s_axi_wready = 1'b0;
        bus.s_axi_bid = '0; bus.s_axi_bresp = '0; bus.s_axi_bvalid = 1'b0;
        bus.s_axi_arready = 1'b0; bus.s_axi_rid = '0; bus.s_axi_rdata = '0;
        bus.s_axi_rresp = '0; bus.s_axi_rlast = 1'b0; bus.s_axi_rvalid = 1'b0;
    endtask

    // Stimulus only: completes a single-beat write burst starting in W_ADDR.
    task automatic finish_write(input int g);
        bus.s_axi_awready = 1'b1;
        tick();
        bus.s_axi_awready = 1'b0;
        bus.m_wvalid[g] = 1'b1; bus.m_wlast[g] = 1'b1; bus.s_axi_wready = 1'b1;
        tick();
        bus.m_wvalid = '0; bus.m_wlast = '0; bus.s_axi_wready = 1'b0;
        bus.s_axi_bvalid = 1'b1; bus.m_bready[g] = 1'b1;
        tick();
        bus.s_axi_bvalid = 1'b0; bus.m_bready = '0;
    endtask

    task automatic test_reset();
        idle_all();
        core_rst = 1'b1;
        init_calib_complete = 1'b0;
        tick(); #1;
        n_vec++; if (bus.s_axi_awvalid !== 1'b0) begin n_err++; $display("FAIL rst_awvalid got %b exp 0", bus.s_axi_awvalid); end
        n_vec++; if (bus.s_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid got %b exp 0", bus.s_axi_arvalid); end
        n_vec++; if (bus.s_axi_awaddr !== 32'h0) begin n_err++; $display("FAIL rst_awaddr got %h exp 0", bus.s_axi_awaddr); end
        n_vec++; if (bus.s_axi_awlen !== 8'h0 || bus.s_axi_awid !== 4'h0) begin n_err++; $display("FAIL rst_awlen_id got %h/%h exp 0/0", bus.s_axi_awlen, bus.s_axi_awid); end
        n_vec++; if (bus.s_axi_awsize !== 3'b110 || bus.s_axi_awburst !== 2'b01 || bus.s_axi_awcache !== 4'b0011) begin n_err++; $display("FAIL attrs got %b/%b/%b exp 110/01/0011", bus.s_axi_awsize, bus.s_axi_awburst, bus.s_axi_awcache); end
        @(negedge core_clk);
        core_rst = 1'b0;
        bus.m_awvalid = 2'b01;
        bus.m_awaddr[31:0] = 32'h0000_0020;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (bus.s_axi_awvalid !== 1'b0 || bus.m_awready !== 2'b00) begin n_err++; $display("FAIL nocal_gate got awvalid=%b awready=%b exp 0/00", bus.s_axi_awvalid, bus.m_awready); end
            tick();
        end
        init_calib_complete = 1'b1;
        #1;
        n_vec++; if (bus.m_awready !== 2'b01) begin n_err++; $display("FAIL cal_awready got %b exp 01", bus.m_awready); end
        tick();
        bus.m_awvalid = '0;
        #1;
        n_vec++; if (bus.s_axi_awvalid !== 1'b1) begin n_err++; $display("FAIL cal_awvalid got %b exp 1", bus.s_axi_awvalid); end
        n_vec++; if (bus.s_axi_awaddr !== 32'h0000_0020 || bus.s_axi_awid !== 4'h0) begin n_err++; $display("FAIL cal_addr got %h id %h exp 00000020 id 0", bus.s_axi_awaddr, bus.s_axi_awid); end
        finish_write(0);
    endtask

    task automatic test_m1_write();
        bus.m_awvalid = 2'b10;
        bus.m_awaddr[63:32] = 32'h0000_0040;
        bus.m_awlen[15:8] = 8'd3;
        #1;
        n_vec++; if (bus.m_awready !== 2'b10) begin n_err++; $display("FAIL m1w_awready got %b exp 10", bus.m_awready); end
        tick();
        bus.m_awvalid = '0;
        #1;
        n_vec++; if (bus.s_axi_awaddr !== 32'h0000_1040 || bus.s_axi_awlen !== 8'd3 || bus.s_axi_awid !== 4'h1) begin n_err++; $display("FAIL m1w_aw got %h len %0d id %0d exp 00001040 len 3 id 1", bus.s_axi_awaddr, bus.s_axi_awlen, bus.s_axi_awid); end
        bus.s_axi_awready = 1'b1;
        tick();
        bus.s_axi_awready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.m_wvalid = 2'b10;
            bus.m_wdata[1023:512] = pat(10 + i);
            bus.m_wdata[511:0] = pat(99);
            bus.m_wlast = (i == 3) ? 2'b10 : 2'b00;
            bus.s_axi_wready = 1'b1;
            #1;
            n_vec++; if (bus.s_axi_wvalid !== 1'b1 || bus.s_axi_wdata !== pat(10 + i) || bus.s_axi_wlast !== (i == 3)) begin n_err++; $display("FAIL m1w_beat%0d got v=%b last=%b d=%h", i, bus.s_axi_wvalid, bus.s_axi_wlast, bus.s_axi_wdata[31:0]); end
            n_vec++; if (bus.m_wready !== 2'b10) begin n_err++; $display("FAIL m1w_wready%0d got %b exp 10", i, bus.m_wready); end
            tick();
        end
        bus.m_wvalid = 2'b10; bus.m_wlast = '0;
        bus.s_axi_bvalid = 1'b1; bus.s_axi_bresp = 2'b10; bus.m_bready = 2'b10;
        #1;
        n_vec++; if (bus.s_axi_wvalid !== 1'b0) begin n_err++; $display("FAIL m1w_extra_beat got wvalid %b exp 0", bus.s_axi_wvalid); end
        n_vec++; if (bus.m_bvalid !== 2'b10 || bus.s_axi_bready !== 1'b1 || bus.m_bresp !== 2'b10) begin n_err++; $display("FAIL m1w_b got bvalid %b bready %b bresp %b exp 10/1/10", bus.m_bvalid, bus.s_axi_bready, bus.m_bresp); end
        tick();
        bus.m_wvalid = '0; bus.m_bready = '0; bus.s_axi_bresp = '0;
        #1;
        n_vec++; if (bus.m_bvalid !== 2'b00) begin n_err++; $display("FAIL m1w_b_done got bvalid %b exp 00", bus.m_bvalid); end
        bus.s_axi_bvalid = 1'b0;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_rdy;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            bus.m_awvalid = 2'b11;
            bus.m_awaddr = {32'h0000_0100, 32'h0000_0200};
            #1;
            n_vec++; if (bus.m_awready !== exp_rdy) begin n_err++; $display("FAIL rr_grant%0d got %b exp %b", i, bus.m_awready, exp_rdy); end
            tick();
            bus.m_awvalid = '0;
            #1;
            n_vec++; if (bus.s_axi_awid !== 4'(i % 2) || bus.s_axi_awaddr !== ((i % 2 == 0) ? 32'h0000_0200 : 32'h0000_1100)) begin n_err++; $display("FAIL rr_aw%0d got id %0d addr %h", i, bus.s_axi_awid, bus.s_axi_awaddr); end
            finish_write(i % 2);
        end
    endtask

    task automatic test_read_concurrent();
        bus.m_arvalid = 2'b01; bus.m_araddr[31:0] = 32'h0000_0080; bus.m_arlen[7:0] = 8'd7;
        bus.m_awvalid = 2'b10; bus.m_awaddr[63:32] = 32'h0000_0010; bus.m_awlen[15:8] = 8'd1;
        #1;
        n_vec++; if (bus.m_arready !== 2'b01 || bus.m_awready !== 2'b10) begin n_err++; $display("FAIL conc_ready got ar %b aw %b exp 01/10", bus.m_arready, bus.m_awready); end
        tick();
        bus.m_arvalid = '0; bus.m_awvalid = '0;
        #1;
        n_vec++; if (bus.s_axi_arvalid !== 1'b1 || bus.s_axi_araddr !== 32'h0000_0080 || bus.s_axi_arlen !== 8'd7 || bus.s_axi_arid !== 4'h0) begin n_err++; $display("FAIL conc_ar got v=%b %h len %0d id %0d", bus.s_axi_arvalid, bus.s_axi_araddr, bus.s_axi_arlen, bus.s_axi_arid); end
        n_vec++; if (bus.s_axi_awvalid !== 1'b1 || bus.s_axi_awaddr !== 32'h0000_1010) begin n_err++; $display("FAIL conc_aw got v=%b %h exp 1 00001010", bus.s_axi_awvalid, bus.s_axi_awaddr); end
        bus.s_axi_arready = 1'b1; bus.s_axi_awready = 1'b1;
        tick();
        bus.s_axi_arready = 1'b0; bus.s_axi_awready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.s_axi_rvalid = 1'b1; bus.s_axi_rdata = pat(20 + i); bus.s_axi_rlast = (i == 7);
            bus.m_rready = 2'b01;
            bus.m_wvalid = (i < 2) ? 2'b10 : 2'b00;
            bus.m_wdata[1023:512] = pat(40 + i);
            bus.m_wlast = (i == 1) ? 2'b10 : 2'b00;
            bus.s_axi_wready = (i < 2);
            bus.s_axi_bvalid = (i == 2);
            bus.m_bready = (i == 2) ? 2'b10 : 2'b00;
            #1;
            n_vec++; if (bus.m_rvalid !== 2'b01 || bus.m_rdata !== pat(20 + i) || bus.m_rlast !== (i == 7) || bus.s_axi_rready !== 1'b1) begin n_err++; $display("FAIL conc_r%0d got rvalid %b last %b rready %b d=%h", i, bus.m_rvalid, bus.m_rlast, bus.s_axi_rready, bus.m_rdata[31:0]); end
            if (i < 2) begin
                n_vec++; if (bus.s_axi_wvalid !== 1'b1 || bus.s_axi_wdata !== pat(40 + i)) begin n_err++; $display("FAIL conc_w%0d got v=%b d=%h", i, bus.s_axi_wvalid, bus.s_axi_wdata[31:0]); end
            end
            if (i == 2) begin
                n_vec++; if (bus.m_bvalid !== 2'b10) begin n_err++; $display("FAIL conc_b got %b exp 10", bus.m_bvalid); end
            end
            tick();
        end
        bus.s_axi_rlast = 1'b0; bus.m_wvalid = '0; bus.m_wlast = '0;
        bus.s_axi_wready = 1'b0; bus.s_axi_bvalid = 1'b0; bus.m_bready = '0;
        #1;
        n_vec++; if (bus.m_rvalid !== 2'b00 || bus.s_axi_rready !== 1'b0) begin n_err++; $display("FAIL conc_r_done got rvalid %b rready %b exp 00/0", bus.m_rvalid, bus.s_axi_rready); end
        bus.s_axi_rvalid = 1'b0; bus.m_rready = '0;
    endtask

    task automatic test_stalls();
        int k;
        int cyc;
        logic rdy;
        bus.m_awvalid = 2'b01; bus.m_awaddr[31:0] = 32'h0000_0300; bus.m_awlen[7:0] = 8'd3;
        tick();
        bus.m_awvalid = '0; bus.s_axi_awready = 1'b1;
        tick();
        bus.s_axi_awready = 1'b0;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 20) begin
            rdy = (cyc % 2 == 0);
            bus.m_wvalid = 2'b01; bus.m_wdata[511:0] = pat(60 + k); bus.m_wlast = (k == 3) ? 2'b01 : 2'b00;
            bus.s_axi_wready = rdy;
            #1;
            n_vec++; if (bus.s_axi_wvalid !== 1'b1 || bus.s_axi_wdata !== pat(60 + k) || bus.s_axi_wlast !== (k == 3) || bus.m_wready !== {1'b0, rdy}) begin n_err++; $display("FAIL stall_w%0d got v=%b last=%b mwr=%b d=%h", k, bus.s_axi_wvalid, bus.s_axi_wlast, bus.m_wready, bus.s_axi_wdata[31:0]); end
            if (rdy) k++;
            cyc++;
            tick();
        end
        n_vec++; if (k != 4) begin n_err++; $display("FAIL stall_w_budget got %0d beats exp 4", k); end
        bus.m_wlast = '0; bus.s_axi_wready = 1'b1;
        bus.s_axi_bvalid = 1'b1; bus.m_bready = 2'b01;
        #1;
        n_vec++; if (bus.s_axi_wvalid !== 1'b0 || bus.m_bvalid !== 2'b01) begin n_err++; $display("FAIL stall_w_end got wvalid %b bvalid %b exp 0/01", bus.s_axi_wvalid, bus.m_bvalid); end
        tick();
        bus.m_wvalid = '0; bus.s_axi_wready = 1'b0; bus.s_axi_bvalid = 1'b0; bus.m_bready = '0;

        bus.m_arvalid = 2'b10; bus.m_araddr[63:32] = 32'hFFFF_F800; bus.m_arlen[15:8] = 8'd3;
        tick();
        bus.m_arvalid = '0;
        #1;
        n_vec++; if (bus.s_axi_araddr !== 32'h0000_0800 || bus.s_axi_arid !== 4'h1) begin n_err++; $display("FAIL wrap_araddr got %h id %0d exp 00000800 id 1", bus.s_axi_araddr, bus.s_axi_arid); end
        bus.s_axi_arready = 1'b1;
        tick();
        bus.s_axi_arready = 1'b0;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 20) begin
            rdy = (cyc % 3 != 1);
            bus.s_axi_rvalid = 1'b1; bus.s_axi_rdata = pat(80 + k); bus.s_axi_rlast = (k == 3);
            bus.m_rready = rdy ? 2'b10 : 2'b01;
            #1;
            n_vec++; if (bus.m_rvalid !== 2'b10 || bus.s_axi_rready !== rdy || bus.m_rdata !== pat(80 + k)) begin n_err++; $display("FAIL stall_r%0d got rvalid %b rready %b d=%h", k, bus.m_rvalid, bus.s_axi_rready, bus.m_rdata[31:0]); end
            if (rdy) k++;
            cyc++;
            tick();
        end
        n_vec++; if (k != 4) begin n_err++; $display("FAIL stall_r_budget got %0d beats exp 4", k); end
        bus.s_axi_rlast = 1'b0; bus.m_rready = 2'b10;
        #1;
        n_vec++; if (bus.m_rvalid !== 2'b00) begin n_err++; $display("FAIL stall_r_end got rvalid %b exp 00", bus.m_rvalid); end
        bus.s_axi_rvalid = 1'b0; bus.m_rready = '0;
    endtask

    task automatic test_reset_mid_burst();
        bus.m_awvalid = 2'b11; bus.m_awaddr = {32'h0000_0020, 32'h0000_0030};
        #1;
        n_vec++; if (bus.m_awready !== 2'b10) begin n_err++; $display("FAIL mid_pre_grant got %b exp 10", bus.m_awready); end
        tick();
        bus.m_awvalid = '0; bus.s_axi_awready = 1'b1;
        tick();
        bus.s_axi_awready = 1'b0;
        bus.m_wvalid = 2'b10; bus.s_axi_wready = 1'b1;
        #1;
        n_vec++; if (bus.s_axi_wvalid !== 1'b1) begin n_err++; $display("FAIL mid_in_data got wvalid %b exp 1", bus.s_axi_wvalid); end
        core_rst = 1'b1;
        #1;
        n_vec++; if (bus.s_axi_wvalid !== 1'b0 || bus.m_wready !== 2'b00 || bus.s_axi_awvalid !== 1'b0 || bus.s_axi_bready !== 1'b0) begin n_err++; $display("FAIL mid_rst_valids got wv %b mwr %b awv %b br %b exp 0", bus.s_axi_wvalid, bus.m_wready, bus.s_axi_awvalid, bus.s_axi_bready); end
        tick();
        core_rst = 1'b0;
        idle_all();
        bus.m_awvalid = 2'b11; bus.m_awaddr = {32'h0000_0020, 32'h0000_0030};
        #1;
        n_vec++; if (bus.m_awready !== 2'b01) begin n_err++; $display("FAIL mid_post_grant got %b exp 01", bus.m_awready); end
        tick();
        bus.m_awvalid = '0;
        #1;
        n_vec++; if (bus.s_axi_awid !== 4'h0 || bus.s_axi_awaddr !== 32'h0000_0030) begin n_err++; $display("FAIL mid_post_aw got id %0d addr %h exp 0 00000030", bus.s_axi_awid, bus.s_axi_awaddr); end
        finish_write(0);
    endtask

    initial begin
        idle_all();
        test_reset();
        test_m1_write();
        test_alternate();
        test_read_concurrent();
        test_stalls();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
